// File: rtl/tile_loader.sv
// tile_loader: fetches a byte stream one MEM_WIDTH word at a time (one outstanding
// read), packs the words into TILE_WIDTH tiles, zero-pads the last partial tile and
// writes each tile to the selected buffer with a one-cycle strobe.
// Ports:
//   control : start/base_addr/length/dest_buffer in; busy/done/len_err out
//   memory  : mem_req/mem_addr out (held until mem_gnt); mem_rvalid/mem_rdata in
//   buffer  : buf_write_enable/data/buffer, buf_reset_indices_enable/buffer out
module tile_loader #(
  parameter int MEM_WIDTH    = 64,
  parameter int ADDR_WIDTH   = 24,
  parameter int LEN_WIDTH    = 16,
  parameter int TILE_WIDTH   = 256,
  parameter int BUFFER_WIDTH = 1024,
  parameter int BUFFER_COUNT = 2,
  localparam int BUF_ID_W    = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [BUF_ID_W-1:0]   dest_buffer,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [MEM_WIDTH-1:0]  mem_rdata,
  output logic                  buf_write_enable,
  output logic [TILE_WIDTH-1:0] buf_write_data,
  output logic [BUF_ID_W-1:0]   buf_write_buffer,
  output logic                  buf_reset_indices_enable,
  output logic [BUF_ID_W-1:0]   buf_reset_indices_buffer
);

  localparam int MEM_BYTES      = MEM_WIDTH / 8;
  localparam int WORDS_PER_TILE = TILE_WIDTH / MEM_WIDTH;
  localparam int BUFFER_BYTES   = BUFFER_WIDTH / 8;
  // One extra value so the word counter can reach WORDS_PER_TILE itself.
  localparam int WIDX_W         = $clog2(WORDS_PER_TILE + 1);

  localparam logic [LEN_WIDTH-1:0]  MEM_BYTES_L = LEN_WIDTH'(MEM_BYTES);
  localparam logic [LEN_WIDTH-1:0]  BUF_BYTES_L = LEN_WIDTH'(BUFFER_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(MEM_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~ADDR_WIDTH'(MEM_BYTES - 1);
  localparam logic [WIDX_W-1:0]     WIDX_FULL   = WIDX_W'(WORDS_PER_TILE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [BUF_ID_W-1:0]     dest_q, dest_d;
  logic                    first_q, first_d;
  logic [WIDX_W-1:0]       word_idx_q, word_idx_d;
  logic [TILE_WIDTH-1:0]   tile_q, tile_d;
  logic                    len_err_q, len_err_d;

  logic [MEM_WIDTH-1:0]    word_masked;
  logic [LEN_WIDTH-1:0]    take;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      dest_q     <= '0;
      first_q    <= 1'b0;
      word_idx_q <= '0;
      tile_q     <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      dest_q     <= dest_d;
      first_q    <= first_d;
      word_idx_q <= word_idx_d;
      tile_q     <= tile_d;
      len_err_q  <= len_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    dest_d      = dest_q;
    first_d     = first_q;
    word_idx_d  = word_idx_q;
    tile_d      = tile_q;
    len_err_d   = len_err_q;
    word_masked = '0;
    take        = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = base_addr & ALIGN_MASK;
          dest_d     = dest_buffer;
          rem_d      = (length > BUF_BYTES_L) ? BUF_BYTES_L : length;
          len_err_d  = (length > BUF_BYTES_L);
          first_d    = 1'b1;
          word_idx_d = '0;
          tile_d     = '0;
          state_d    = (length == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          addr_d  = addr_q + ADDR_STEP;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          // Bytes past the end of the load are dropped so the tail of the tile is zero.
          for (int j = 0; j < MEM_BYTES; j++) begin
            if (LEN_WIDTH'(j) < rem_q) word_masked[8*j +: 8] = mem_rdata[8*j +: 8];
          end
          for (int w = 0; w < WORDS_PER_TILE; w++) begin
            if (word_idx_q == WIDX_W'(w)) tile_d[w*MEM_WIDTH +: MEM_WIDTH] = word_masked;
          end
          take       = (rem_q < MEM_BYTES_L) ? rem_q : MEM_BYTES_L;
          rem_d      = rem_q - take;
          word_idx_d = word_idx_q + WIDX_W'(1);
          state_d    = (word_idx_d == WIDX_FULL || rem_d == '0) ? S_WRITE : S_REQ;
        end
      end
      S_WRITE: begin
        first_d    = 1'b0;
        word_idx_d = '0;
        tile_d     = '0;
        state_d    = (rem_q != '0) ? S_REQ : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs decode straight from registers; nothing combinational from inputs.
  assign busy                     = (state_q != S_IDLE);
  assign done                     = (state_q == S_DONE);
  assign len_err                  = len_err_q;
  assign mem_req                  = (state_q == S_REQ);
  assign mem_addr                 = addr_q;
  assign buf_write_enable         = (state_q == S_WRITE);
  assign buf_write_data           = tile_q;
  assign buf_write_buffer         = dest_q;
  assign buf_reset_indices_enable = (state_q == S_WRITE) && first_q;
  assign buf_reset_indices_buffer = dest_q;

endmodule
